// File: rtl/alu_mdu_sequencer.sv
// ALU operation decoder plus a multi-cycle multiply/divide sequencer (shift-add / restoring).
// Define ALU_MDU_DIV_EN to build the divider; otherwise divide/remainder ops return all ones.
module alu_mdu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic             RType,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [3:0]       Operation,
  output logic             ready_o,
  output logic             stall_o,
  output logic             md_valid_o,
  output logic [WIDTH-1:0] md_result
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

`ifdef ALU_MDU_DIV_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
`endif

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_b, r_result;
  logic [2:0]         r_f3;
  logic               r_neg_q;

  logic               w_mop, w_accept, w_last, w_a_neg, w_b_neg, w_fast, w_load;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_fast_res, w_res, w_step_hi, w_step_lo;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;

  assign w_mop    = valid_i && (ALUOp == 2'b10) && RType && (Funct7 == 7'b0000001);
  assign w_accept = (r_state == IDLE) && w_mop && !flush_i;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    Operation = 4'b0010;
    case (ALUOp)
      2'b00: Operation = 4'b0010;
      2'b01: begin
        case (Funct3)
          3'b001:  Operation = 4'b1001;
          3'b100:  Operation = 4'b1100;
          3'b101:  Operation = 4'b1101;
          default: Operation = 4'b1000;
        endcase
      end
      2'b10: begin
        case (Funct3)
          3'b000:  Operation = (RType && Funct7 == 7'b0100000) ? 4'b0011 : 4'b0010;
          3'b001:  Operation = 4'b0110;
          3'b010:  Operation = 4'b1110;
          3'b011:  Operation = 4'b1111;
          3'b100:  Operation = 4'b0100;
          3'b101:  Operation = (Funct7 == 7'b0100000) ? 4'b0111 : 4'b0101;
          3'b110:  Operation = 4'b0001;
          default: Operation = 4'b0000;
        endcase
      end
      default: Operation = 4'b1010;
    endcase
    if (w_mop) Operation = 4'b0010;
  end

  // Signed ops run on magnitudes; the sign is re-applied to the full result at the end.
  assign w_a_neg = SrcA[WIDTH-1] & ((Funct3 == 3'b001) | (Funct3 == 3'b010) | (Funct3[2] & ~Funct3[0]));
  assign w_b_neg = SrcB[WIDTH-1] & ((Funct3 == 3'b001) | (Funct3[2] & ~Funct3[0]));
  assign w_mag_a = w_a_neg ? -SrcA : SrcA;
  assign w_mag_b = w_b_neg ? -SrcB : SrcB;

  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_prod   = {w_sum[WIDTH:1], w_sum[0], r_lo[WIDTH-1:1]};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;

`ifdef ALU_MDU_DIV_EN
  logic               r_neg_r;
  logic [WIDTH:0]     w_shift, w_diff;
  logic               w_ge, w_div_zero, w_ovf;
  logic [WIDTH-1:0]   w_dhi, w_dlo, w_quo, w_rem;

  // Remainder stays below the divisor, so bit WIDTH of the difference is a pure borrow flag.
  assign w_shift    = {r_hi, r_lo[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_b};
  assign w_ge       = ~w_diff[WIDTH];
  assign w_dhi      = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_dlo      = {r_lo[WIDTH-2:0], w_ge};
  assign w_quo      = r_neg_q ? -w_dlo : w_dlo;
  assign w_rem      = r_neg_r ? -w_dhi : w_dhi;
  assign w_div_zero = (SrcB == '0);
  assign w_ovf      = ~Funct3[0] && (SrcA == MOST_NEG) && (SrcB == '1);
  assign w_fast     = Funct3[2] && (w_div_zero || w_ovf);
  assign w_fast_res = w_div_zero ? (Funct3[1] ? SrcA : '1) : (Funct3[1] ? '0 : MOST_NEG);
`else
  assign w_fast     = Funct3[2];
  assign w_fast_res = '1;
`endif

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_res     = w_fast_res;
    w_step_hi = w_sum[WIDTH:1];
    w_step_lo = w_prod[WIDTH-1:0];
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_fast) begin
            w_next = DONE;
            w_load = 1'b1;
          end else begin
            w_next = MUL;
`ifdef ALU_MDU_DIV_EN
            if (Funct3[2]) w_next = DIV;
`endif
          end
        end
      end
      MUL: begin
        if (w_last) begin
          w_next = DONE;
          w_load = 1'b1;
          w_res  = (r_f3 == 3'b000) ? w_prod_s[WIDTH-1:0] : w_prod_s[2*WIDTH-1:WIDTH];
        end
      end
`ifdef ALU_MDU_DIV_EN
      DIV: begin
        w_step_hi = w_dhi;
        w_step_lo = w_dlo;
        if (w_last) begin
          w_next = DONE;
          w_load = 1'b1;
          w_res  = r_f3[1] ? w_rem : w_quo;
        end
      end
`endif
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (flush_i) begin
      w_next = IDLE;
      w_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_f3     <= '0;
      r_neg_q  <= 1'b0;
      r_result <= '0;
`ifdef ALU_MDU_DIV_EN
      r_neg_r  <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_hi    <= '0;
        r_lo    <= w_mag_a;
        r_b     <= w_mag_b;
        r_f3    <= Funct3;
        r_neg_q <= w_a_neg ^ w_b_neg;
`ifdef ALU_MDU_DIV_EN
        r_neg_r <= w_a_neg;
`endif
      end else if (r_state != IDLE && r_state != DONE) begin
        r_cnt <= r_cnt + 1'b1;
        r_hi  <= w_step_hi;
        r_lo  <= w_step_lo;
      end
      if (w_load) r_result <= w_res;
    end
  end

  assign ready_o    = (r_state == IDLE);
  assign md_valid_o = (r_state == DONE);
  assign stall_o    = w_accept || (r_state != IDLE && r_state != DONE);
  assign md_result  = r_result;

endmodule

// File: tb/tb_alu_mdu_sequencer.sv
// Self-checking bench for alu_mdu_sequencer at WIDTH=32: decode table, multiply/divide
// scoreboard, flush and asynchronous reset sequences.
module tb_alu_mdu_sequencer;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, valid_i, flush_i, RType;
  logic [1:0]   ALUOp;
  logic [6:0]   Funct7;
  logic [2:0]   Funct3;
  logic [W-1:0] SrcA, SrcB;
  logic [3:0]   Operation;
  logic         ready_o, stall_o, md_valid_o;
  logic [W-1:0] md_result;

  alu_mdu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .RType(RType),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ready_o(ready_o),
    .stall_o(stall_o), .md_valid_o(md_valid_o), .md_result(md_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] aluop; logic [6:0] f7; logic [2:0] f3; logic rtype; logic valid; logic [3:0] exp;
  } op_vec_t;
  typedef struct {
    logic [2:0] f3; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] res; int lat;
  } md_vec_t;
  typedef struct {
    logic [W-1:0] res; int lat; int c0;
  } sb_t;

  sb_t          sb_q[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] last_exp = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void ref_md(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] res, output int lat);
    logic [63:0] ea, eb, p;
    lat = W + 1;
    res = '0;
    if (!f3[2]) begin
      ea  = (f3 == 3'b001 || f3 == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
      eb  = (f3 == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
      p   = ea * eb;
      res = (f3 == 3'b000) ? p[31:0] : p[63:32];
    end else begin
`ifdef ALU_MDU_DIV_EN
      if (b == 0) begin
        res = f3[1] ? a : '1; lat = 1;
      end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        res = f3[1] ? '0 : a; lat = 1;
      end else if (!f3[0]) begin
        res = f3[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
      end else begin
        res = f3[1] ? a % b : a / b;
      end
`else
      res = '1; lat = 1;
`endif
    end
  endfunction

  task automatic drive_mop(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
    ALUOp = 2'b10; RType = 1'b1; Funct7 = 7'b0000001; Funct3 = f3; SrcA = a; SrcB = b; valid_i = 1'b1;
  endtask

  task automatic run_md(input string name, input logic [2:0] f3, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    sb_t e;
    int  stall_cnt;
    bit  got;
    stall_cnt = 0;
    got = 0;
    @(posedge clk); #1;
    drive_mop(f3, a, b);
    sb_q.push_back('{exp, lat, cyc});
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (stall_o) stall_cnt++;
      if (md_valid_o) begin
        got = 1;
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s: md_valid_o with empty scoreboard", name);
        end else begin
          e = sb_q.pop_front();
          check({name, " result"}, md_result, e.res);
          check({name, " latency"}, cyc - e.c0, e.lat);
        end
      end
      @(posedge clk); #1;
      // A second, different M-op arriving while busy must be ignored.
      if (k == 0) drive_mop(f3 ^ 3'b011, ~a, b + 1);
      else valid_i = 1'b0;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s: no md_valid_o within budget, got none expected pulse", name);
      void'(sb_q.pop_front());
    end
    valid_i = 1'b0;
    check({name, " stall cycles"}, stall_cnt, lat);
    @(negedge clk);
    check({name, " single pulse"}, {md_valid_o, ready_o}, 2'b01);
    last_exp = exp;
  endtask

  task automatic watch_quiet(input string name, input int n);
    int pulses;
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (md_valid_o) pulses++;
    end
    check({name, " no md_valid_o"}, pulses, 0);
  endtask

  op_vec_t ov[21];
  md_vec_t mv[18];

  initial begin
    logic [W-1:0] r_exp;
    int           r_lat, c0;
    logic [2:0]   rf3;
    logic [W-1:0] ra, rb;

    ov[0]  = '{2'b00, 7'h00, 3'b000, 1'b0, 1'b0, 4'b0010};
    ov[1]  = '{2'b11, 7'h00, 3'b000, 1'b0, 1'b0, 4'b1010};
    ov[2]  = '{2'b01, 7'h00, 3'b000, 1'b0, 1'b0, 4'b1000};
    ov[3]  = '{2'b01, 7'h00, 3'b001, 1'b0, 1'b0, 4'b1001};
    ov[4]  = '{2'b01, 7'h00, 3'b100, 1'b0, 1'b0, 4'b1100};
    ov[5]  = '{2'b01, 7'h00, 3'b101, 1'b0, 1'b0, 4'b1101};
    ov[6]  = '{2'b01, 7'h00, 3'b010, 1'b0, 1'b0, 4'b1000};
    ov[7]  = '{2'b01, 7'h00, 3'b111, 1'b0, 1'b0, 4'b1000};
    ov[8]  = '{2'b10, 7'h20, 3'b000, 1'b1, 1'b0, 4'b0011};
    ov[9]  = '{2'b10, 7'h20, 3'b000, 1'b0, 1'b0, 4'b0010};
    ov[10] = '{2'b10, 7'h00, 3'b001, 1'b1, 1'b0, 4'b0110};
    ov[11] = '{2'b10, 7'h00, 3'b010, 1'b1, 1'b0, 4'b1110};
    ov[12] = '{2'b10, 7'h00, 3'b011, 1'b1, 1'b0, 4'b1111};
    ov[13] = '{2'b10, 7'h00, 3'b100, 1'b1, 1'b0, 4'b0100};
    ov[14] = '{2'b10, 7'h20, 3'b101, 1'b0, 1'b0, 4'b0111};
    ov[15] = '{2'b10, 7'h00, 3'b101, 1'b1, 1'b0, 4'b0101};
    ov[16] = '{2'b10, 7'h00, 3'b110, 1'b1, 1'b0, 4'b0001};
    ov[17] = '{2'b10, 7'h00, 3'b111, 1'b1, 1'b0, 4'b0000};
    ov[18] = '{2'b10, 7'h01, 3'b111, 1'b1, 1'b1, 4'b0010};
    ov[19] = '{2'b10, 7'h01, 3'b111, 1'b1, 1'b0, 4'b0000};
    ov[20] = '{2'b10, 7'h01, 3'b001, 1'b0, 1'b1, 4'b0110};

    mv[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    mv[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    mv[2]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    mv[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    mv[4]  = '{3'b001, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 33};
    mv[5]  = '{3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33};
    mv[6]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    mv[7]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    mv[8]  = '{3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    mv[9]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    mv[10] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    mv[11] = '{3'b111, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 1};
    mv[12] = '{3'b101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 33};
    mv[13] = '{3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 33};
    mv[14] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    mv[15] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    mv[16] = '{3'b100, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    mv[17] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};

    reset = 1'b0; valid_i = 1'b0; flush_i = 1'b0; RType = 1'b0;
    ALUOp = 2'b00; Funct7 = '0; Funct3 = '0; SrcA = '0; SrcB = '0;
    #2;
    check("reset state", {ready_o, stall_o, md_valid_o, md_result}, {1'b1, 1'b0, 1'b0, 32'h0});
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Decode table; flush_i held high so M-op rows cannot start the sequencer.
    flush_i = 1'b1;
    for (int i = 0; i < 21; i++) begin
      ALUOp = ov[i].aluop; Funct7 = ov[i].f7; Funct3 = ov[i].f3;
      RType = ov[i].rtype; valid_i = ov[i].valid;
      #1;
      check($sformatf("Operation row %0d", i), Operation, ov[i].exp);
    end
    valid_i = 1'b0;
    flush_i = 1'b0;

    for (int i = 0; i < 18; i++) begin
      r_exp = mv[i].res;
      r_lat = mv[i].lat;
`ifndef ALU_MDU_DIV_EN
      if (mv[i].f3[2]) begin
        r_exp = '1;
        r_lat = 1;
      end
`endif
      run_md($sformatf("md row %0d", i), mv[i].f3, mv[i].a, mv[i].b, r_exp, r_lat);
    end

    for (int i = 0; i < 8; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 4 == 3) ? 32'($urandom_range(0, 9)) : $urandom;
      ref_md(rf3, ra, rb, r_exp, r_lat);
      run_md($sformatf("rand %0d f3=%0d", i, rf3), rf3, ra, rb, r_exp, r_lat);
    end

    // flush_i in IDLE blocks acceptance.
    @(posedge clk); #1;
    drive_mop(3'b000, 32'd3, 32'd5);
    flush_i = 1'b1;
    #2;
    check("idle flush stall", stall_o, 1'b0);
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    check("idle flush ready", ready_o, 1'b1);
    watch_quiet("idle flush", 5);

    // Flush at cycle 10 of a multiply.
    @(posedge clk); #1;
    drive_mop(3'b000, 32'h0000_0007, 32'hFFFF_FFFD);
    c0 = cyc;
    sb_q.push_back('{32'hFFFF_FFEB, 33, c0});
    @(posedge clk); #1;
    valid_i = 1'b0;
    for (int k = 0; k < 20 && cyc < c0 + 10; k++) begin
      @(posedge clk); #1;
    end
    check("flush cycle", cyc - c0, 10);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush ready", {ready_o, stall_o, md_valid_o}, 3'b100);
    void'(sb_q.pop_front());
    watch_quiet("flush", 40);
    check("flush md_result held", md_result, last_exp);
    run_md("after flush", 3'b001, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 33);

    // Asynchronous reset at cycle 5 of an iterative op.
    @(posedge clk); #1;
`ifdef ALU_MDU_DIV_EN
    drive_mop(3'b100, 32'hFFFF_FFF9, 32'h0000_0002);
    sb_q.push_back('{32'hFFFF_FFFD, 33, cyc});
`else
    drive_mop(3'b000, 32'h0000_0007, 32'hFFFF_FFFD);
    sb_q.push_back('{32'hFFFF_FFEB, 33, cyc});
`endif
    c0 = cyc;
    @(posedge clk); #1;
    valid_i = 1'b0;
    for (int k = 0; k < 20 && cyc < c0 + 5; k++) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b0;
    #1;
    check("async reset outputs", {ready_o, stall_o, md_valid_o, md_result}, {1'b1, 1'b0, 1'b0, 32'h0});
    @(posedge clk); #1;
    reset = 1'b1;
    void'(sb_q.pop_front());
    watch_quiet("after reset", 40);
    check("after reset md_result", md_result, 32'h0);
    run_md("after reset", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);

    check("scoreboard drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mdu_sequencer.md
ALU_MDU_SEQUENCER -- requirements
Module: alu_mdu_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 valid_i  input  1  decode fields and operands valid this cycle.
REQ-005 flush_i  input  1  synchronous abort of an in-flight multiply/divide.
REQ-006 ALUOp  input  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI.
REQ-007 Funct7  input  7  instruction bits 31:25.
REQ-008 Funct3  input  3  instruction bits 14:12.
REQ-009 RType  input  1  1 = R-type instruction (Funct7 is a real field, not immediate).
REQ-010 SrcA, SrcB  input  WIDTH  operands for multiply/divide.
REQ-011 Operation  output  4  ALU operation code.
REQ-012 ready_o  output  1  sequencer idle, can accept a multiply/divide.
REQ-013 stall_o  output  1  hold upstream pipeline.
REQ-014 md_valid_o  output  1  one-cycle pulse, md_result valid.
REQ-015 md_result  output  WIDTH  multiply/divide result.

Function
REQ-016 Operation SHALL be combinational: ALUOp 00 -> 0010; 11 -> 1010; 01 with Funct3 000/001/100/101 -> 1000/1001/1100/1101, other Funct3 -> 1000.
REQ-017 ALUOp 10, Funct3 000 -> 0011 if RType and Funct7=0100000, else 0010; 001 -> 0110; 010 -> 1110; 011 -> 1111; 100 -> 0100; 101 -> 0111 if Funct7=0100000 else 0101; 110 -> 0001; 111 -> 0000.
REQ-018 M-op = valid_i & ALUOp=10 & RType & Funct7=0000001; Operation SHALL be 0010 for any M-op.
REQ-019 FSM states IDLE, MUL, DIV, DONE; ready_o = (state==IDLE).
REQ-020 IDLE: M-op with Funct3[2]=0 -> MUL; Funct3[2]=1 -> DIV, except fast cases (REQ-024/025) -> DONE directly; non-M-op stays IDLE.
REQ-021 MUL/DIV SHALL iterate exactly WIDTH cycles (shift-add / restoring), counter width $clog2(WIDTH)+1, then -> DONE; DONE -> IDLE unconditionally.
REQ-022 Funct3: 000 MUL low half, 001 MULH s*s high, 010 MULHSU s*u high, 011 MULHU u*u high, 100 DIV, 101 DIVU, 110 REM, 111 REMU; signed ops by magnitude with sign correction of 2*WIDTH product / quotient / remainder (remainder takes dividend sign).
REQ-023 Operands, Funct3 latched at accept; later input changes SHALL NOT affect the result.
REQ-024 Divide by zero: quotient all ones, remainder = dividend, latency 1 (DONE next cycle).
REQ-025 Signed overflow (SrcA = most negative, SrcB = -1): DIV = most negative, REM = 0, latency 1.
REQ-026 md_valid_o SHALL be high only in DONE; md_result holds last value until next DONE.
REQ-027 stall_o = M-op accepted in IDLE (combinational) | state in {MUL, DIV}; low in DONE.
REQ-028 Iterative latency: accept at cycle 0, md_valid_o at cycle WIDTH+1.
REQ-029 flush_i in MUL/DIV/DONE -> IDLE next edge, no md_valid_o pulse, md_result unchanged; flush_i in IDLE SHALL block acceptance that cycle; flush_i has priority over all transitions.
REQ-030 valid_i while not IDLE SHALL be ignored (upstream is stalled).

Reset
REQ-031 reset low SHALL immediately force IDLE, counter 0, md_valid_o 0, md_result 0, internal operand/accumulator registers 0, regardless of operation in flight.
REQ-032 Release SHALL be synchronised externally; first accepting edge is the first clk after reset high.

Configuration
REQ-033 Macro ALU_MDU_DIV_EN: defined -> divide/remainder (Funct3[2]=1) supported as above.
REQ-034 Undefined -> DIV state and divider datapath absent; Funct3[2]=1 M-ops go IDLE -> DONE with md_result all ones, latency 1; multiply unchanged.

Verification
REQ-035 ALUOp=10, RType=1, Funct3=000, Funct7=0100000 -> Operation=0011; same with RType=0 -> 0010.
REQ-036 MUL SrcA=7, SrcB=0xFFFFFFFD (WIDTH=32) -> stall_o high cycles 0..32, md_valid_o at cycle 33, md_result=0xFFFFFFEB; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-037 DIV SrcA=0xFFFFFFF9 (-7), SrcB=2 -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF; at cycle 33.
REQ-038 DIVU SrcA=5, SrcB=0 -> md_result=0xFFFFFFFF at cycle 1; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1.
REQ-039 flush_i at cycle 10 of MUL -> IDLE at cycle 11, no md_valid_o, ready_o=1; next MUL completes correctly.
REQ-040 reset low at cycle 5 of DIV -> outputs zero immediately, no md_valid_o after release; without ALU_MDU_DIV_EN, DIV -> all ones at cycle 1.
